video_effect_stage: RTL and testbench

- Avalon-ST pixel-processing stage directly downstream of the video pattern/ROM streamer; upstream of the VGA output module.
- Takes 30-bit RGB beats (8 colour bits + 2 pad bits per channel) and applies a per-frame colour effect: pass, invert, grayscale or saturating brightness.
- Two-stage valid/ready pipeline with full backpressure support and no data loss.
- Also checks frame framing (sop/eop position vs NumPixels) and counts good frames.

---
 rtl/video_effect_stage.sv | 153 +++++++++++++++
 tb/tb_video_effect_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_effect_stage.sv
// Two-stage Avalon-ST colour effect stage: per-frame effect latch, stage-1 pixel math,
// stage-2 output register, plus sop/eop framing check and good-frame counter.
module video_effect_stage #(
  parameter int NumPixels      = 12*12,
  parameter int FrameCountBits = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [29:0]               sink_data,
  input  logic                      sink_startofpacket,
  input  logic                      sink_endofpacket,
  input  logic                      sink_valid,
  output logic                      sink_ready,
  output logic [29:0]               src_data,
  output logic                      src_startofpacket,
  output logic                      src_endofpacket,
  output logic                      src_valid,
  input  logic                      src_ready,
  input  logic [1:0]                effect_sel,
  input  logic [7:0]                brightness_offset,
  output logic                      frame_error,
  output logic [FrameCountBits-1:0] frame_count
);

  localparam int CntBits = (NumPixels > 1) ? $clog2(NumPixels) : 1;
  localparam logic [CntBits-1:0] LastIdx = CntBits'(NumPixels - 1);

  typedef enum logic [1:0] {EffPass, EffInvert, EffGray, EffBright} effect_e;

  logic                      r_v1, r_v2;
  logic [23:0]               r_d1, r_d2;
  logic                      r_sop1, r_eop1, r_sop2, r_eop2;
  effect_e                   r_eff;
  logic [7:0]                r_off;
  logic [CntBits-1:0]        r_cnt;
  logic                      r_ferr;
  logic [FrameCountBits-1:0] r_fc;

  logic               w_adv1, w_adv2, w_accept, w_sop_acc;
  effect_e            w_eff;
  logic [7:0]         w_off;
  logic [7:0]         w_r, w_g, w_b;
  logic [9:0]         w_gray_sum;
  logic [23:0]        w_pix;
  logic [CntBits-1:0] w_pos, w_cnt_nxt;
  logic               w_ok, w_err, w_good;
  logic               w_unused_pad;

  assign w_adv2     = !r_v2 || src_ready;
  assign w_adv1     = !r_v1 || w_adv2;
  assign sink_ready = reset && w_adv1;
  assign w_accept   = sink_valid && sink_ready;
  assign w_sop_acc  = w_accept && sink_startofpacket;

  // The sop beat itself must see the freshly sampled controls, so bypass the latch.
  assign w_eff = w_sop_acc ? effect_e'(effect_sel) : r_eff;
  assign w_off = w_sop_acc ? brightness_offset : r_off;

  assign w_r          = sink_data[29:22];
  assign w_g          = sink_data[19:12];
  assign w_b          = sink_data[9:2];
  assign w_unused_pad = ^{sink_data[21:20], sink_data[11:10], sink_data[1:0]};
  assign w_gray_sum   = {2'b00, w_r} + {1'b0, w_g, 1'b0} + {2'b00, w_b};

  function automatic logic [7:0] brighten(input logic [7:0] c, input logic [7:0] off);
    logic [9:0] s;
    s = {2'b00, c} + {{2{off[7]}}, off};
    if (s[9])      return 8'h00;
    else if (s[8]) return 8'hFF;
    else           return s[7:0];
  endfunction

  always_comb begin
    w_pix = {w_r, w_g, w_b};
    case (w_eff)
      EffPass:   w_pix = {w_r, w_g, w_b};
      EffInvert: w_pix = {~w_r, ~w_g, ~w_b};
      EffGray:   w_pix = {3{w_gray_sum[9:2]}};
      EffBright: w_pix = {brighten(w_r, w_off), brighten(w_g, w_off), brighten(w_b, w_off)};
      default:   w_pix = {w_r, w_g, w_b};
    endcase
  end

  // A frame is in progress exactly when cnt != 0, so no separate "started" flag is kept.
  assign w_pos = sink_startofpacket ? '0 : r_cnt;
  assign w_ok  = sink_startofpacket || (r_cnt != '0);

  always_comb begin
    w_err     = 1'b0;
    w_good    = 1'b0;
    w_cnt_nxt = r_cnt;
    if (sink_startofpacket && r_cnt != '0) w_err = 1'b1;
    if (!sink_startofpacket && r_cnt == '0) w_err = 1'b1;
    if (sink_endofpacket) begin
      w_cnt_nxt = '0;
      if (w_pos != LastIdx) w_err  = 1'b1;
      else if (w_ok)        w_good = 1'b1;
    end else if (w_pos == LastIdx) begin
      w_err     = 1'b1;
      w_cnt_nxt = '0;
    end else if (w_ok) begin
      w_cnt_nxt = w_pos + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_d1   <= '0;
      r_d2   <= '0;
      r_sop1 <= 1'b0;
      r_eop1 <= 1'b0;
      r_sop2 <= 1'b0;
      r_eop2 <= 1'b0;
      r_eff  <= EffPass;
      r_off  <= '0;
      r_cnt  <= '0;
      r_ferr <= 1'b0;
      r_fc   <= '0;
    end else begin
      if (w_adv1) r_v1 <= sink_valid;
      if (w_accept) begin
        r_d1   <= w_pix;
        r_sop1 <= sink_startofpacket;
        r_eop1 <= sink_endofpacket;
        r_cnt  <= w_cnt_nxt;
        if (w_good) r_fc <= r_fc + 1'b1;
      end
      if (w_sop_acc) begin
        r_eff <= w_eff;
        r_off <= w_off;
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_d2   <= r_d1;
          r_sop2 <= r_sop1;
          r_eop2 <= r_eop1;
        end
      end
      r_ferr <= w_accept && w_err;
    end
  end

  assign src_valid         = r_v2;
  assign src_data          = {r_d2[23:16], 2'b00, r_d2[15:8], 2'b00, r_d2[7:0], 2'b00};
  assign src_startofpacket = r_sop2;
  assign src_endofpacket   = r_eop2;
  assign frame_error       = r_ferr;
  assign frame_count       = r_fc;

endmodule

// File: tb/tb_video_effect_stage.sv
// Directed bench for video_effect_stage: scoreboard of expected output beats,
// framing-error and frame-count checks, random backpressure and mid-frame reset.
module tb_video_effect_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] sink_data;
  logic        sink_startofpacket, sink_endofpacket, sink_valid, sink_ready;
  logic [29:0] src_data;
  logic        src_startofpacket, src_endofpacket, src_valid;
  logic        src_ready;
  logic [1:0]  effect_sel;
  logic [7:0]  brightness_offset;
  logic        frame_error;
  logic [15:0] frame_count;

  video_effect_stage #(.NumPixels(144), .FrameCountBits(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .sink_data          (sink_data),
    .sink_startofpacket (sink_startofpacket),
    .sink_endofpacket   (sink_endofpacket),
    .sink_valid         (sink_valid),
    .sink_ready         (sink_ready),
    .src_data           (src_data),
    .src_startofpacket  (src_startofpacket),
    .src_endofpacket    (src_endofpacket),
    .src_valid          (src_valid),
    .src_ready          (src_ready),
    .effect_sel         (effect_sel),
    .brightness_offset  (brightness_offset),
    .frame_error        (frame_error),
    .frame_count        (frame_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          err_pulses = 0;
  int          acc_cyc = 0;
  logic        lat_arm_req = 1'b0;
  logic        lat_armed   = 1'b0;
  logic        rnd_ready   = 1'b0;
  logic [31:0] sb[$];
  logic [1:0]  m_eff = 2'd0;
  logic [7:0]  m_off = 8'd0;
  logic        stall_q = 1'b0;
  logic [31:0] stall_val = '0;
  int          exp_fc = 0;
  int          pulses_snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [7:0] o);
    int t;
    t = int'(c) + int'($signed(o));
    if (t < 0)   return 8'h00;
    if (t > 255) return 8'hFF;
    return 8'(t);
  endfunction

  function automatic logic [29:0] model(input logic [29:0] d, input logic [1:0] e, input logic [7:0] o);
    logic [7:0] r, g, b, y;
    r = d[29:22]; g = d[19:12]; b = d[9:2];
    case (e)
      2'd1: begin r = 8'd255 - r; g = 8'd255 - g; b = 8'd255 - b; end
      2'd2: begin y = 8'((int'(r) + 2*int'(g) + int'(b)) / 4); r = y; g = y; b = y; end
      2'd3: begin r = sat_add(r, o); g = sat_add(g, o); b = sat_add(b, o); end
      default: ;
    endcase
    return {r, 2'b00, g, 2'b00, b, 2'b00};
  endfunction

  always @(posedge clk) cyc++;

  initial begin
    src_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      src_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pops, stall stability, latency, error pulse count.
  always @(negedge clk) begin
    if (frame_error) err_pulses++;
    if (stall_q && reset) begin
      check("stall_valid", 32'(src_valid), 32'd1);
      check("stall_hold", {src_startofpacket, src_endofpacket, src_data}, stall_val);
    end
    stall_q   = reset && src_valid && !src_ready;
    stall_val = {src_startofpacket, src_endofpacket, src_data};
    if (lat_armed && src_valid) begin
      check("latency", 32'(cyc - acc_cyc), 32'd2);
      lat_armed = 1'b0;
    end
    if (reset && src_valid && src_ready) begin
      if (sb.size() == 0) check("sb_unexpected_beat", 32'(sb.size()), 32'd1);
      else check("beat", {src_startofpacket, src_endofpacket, src_data}, sb.pop_front());
    end
  end

  task automatic send_beat(input logic [29:0] d, input logic sop, input logic eop,
                           input logic [1:0] e, input logic [7:0] o, input logic exp_err,
                           input logic use_exp, input logic [29:0] exp_d);
    logic acc;
    sink_data = d; sink_startofpacket = sop; sink_endofpacket = eop;
    effect_sel = e; brightness_offset = o; sink_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 1000 && !acc; k++) begin
      @(negedge clk);
      if (sink_ready) begin
        acc = 1'b1;
        if (sop) begin m_eff = e; m_off = o; end
        sb.push_back({sop, eop, use_exp ? exp_d : model(d, m_eff, m_off)});
        if (lat_arm_req) begin acc_cyc = cyc; lat_armed = 1'b1; lat_arm_req = 1'b0; end
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      $display("FAIL accept_timeout sink_ready stuck low");
      $fatal(1, "accept timeout");
    end
    check("frame_error", 32'(frame_error), 32'(exp_err));
  endtask

  task automatic send_frame(input int n, input int eop_pos, input logic [1:0] e, input logic [7:0] o,
                            input int toggle_at, input int err_at, input logic [29:0] p0,
                            input logic use_exp0, input logic [29:0] exp0);
    logic [29:0] d;
    logic [1:0]  ee;
    for (int i = 0; i < n; i++) begin
      d  = (i == 0) ? p0 : 30'($urandom);
      ee = (toggle_at >= 0 && i >= toggle_at) ? (e ^ 2'b01) : e;
      send_beat(d, i == 0, i == eop_pos, ee, o, i == err_at, use_exp0 && i == 0, exp0);
    end
    sink_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 3000; k++) begin
      if (sb.size() == 0 && !src_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; sink_valid = 1'b0; sink_data = '0;
    sink_startofpacket = 1'b0; sink_endofpacket = 1'b0;
    effect_sel = 2'd0; brightness_offset = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_src_valid", 32'(src_valid), 32'd0);
    check("rst_sink_ready", 32'(sink_ready), 32'd0);
    check("rst_src_data", 32'(src_data), 32'd0);
    check("rst_sop_eop", {30'd0, src_startofpacket, src_endofpacket}, 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    reset = 1'b1;
    lat_arm_req = 1'b1;

    send_frame(144, 143, 2'd0, 8'h00, -1, -1, 30'h3FFFFFFF, 1'b1, {8'hFF, 2'b00, 8'hFF, 2'b00, 8'hFF, 2'b00});
    drain(); exp_fc++;
    check("fc_pass", 32'(frame_count), 32'(exp_fc));

    send_frame(144, 143, 2'd1, 8'h00, 50, -1, {8'h10, 2'b11, 8'h80, 2'b11, 8'hFF, 2'b11}, 1'b1,
               {8'hEF, 2'b00, 8'h7F, 2'b00, 8'h00, 2'b00});
    send_frame(144, 143, 2'd2, 8'h00, -1, -1, {8'h40, 2'b01, 8'h80, 2'b10, 8'hC0, 2'b01}, 1'b1,
               {8'h80, 2'b00, 8'h80, 2'b00, 8'h80, 2'b00});
    send_frame(144, 143, 2'd3, 8'h20, 50, -1, {8'hF0, 2'b00, 8'h10, 2'b00, 8'h50, 2'b00}, 1'b1,
               {8'hFF, 2'b00, 8'h30, 2'b00, 8'h70, 2'b00});
    send_frame(144, 143, 2'd3, 8'hE0, -1, -1, {8'hF0, 2'b00, 8'h10, 2'b00, 8'h50, 2'b00}, 1'b1,
               {8'hD0, 2'b00, 8'h00, 2'b00, 8'h30, 2'b00});
    drain(); exp_fc += 4;
    check("fc_effects", 32'(frame_count), 32'(exp_fc));
    check("no_error_pulses", 32'(err_pulses), 32'd0);

    rnd_ready = 1'b1;
    send_frame(144, 143, 2'd3, 8'($urandom), -1, -1, 30'($urandom), 1'b0, '0);
    send_frame(144, 143, 2'd1, 8'h00, 70, -1, 30'($urandom), 1'b0, '0);
    send_frame(144, 143, 2'd2, 8'h00, -1, -1, 30'($urandom), 1'b0, '0);
    drain(); exp_fc += 3;
    rnd_ready = 1'b0;
    check("fc_backpressure", 32'(frame_count), 32'(exp_fc));

    pulses_snap = err_pulses;
    send_frame(100, 99, 2'd0, 8'h00, -1, 99, 30'($urandom), 1'b0, '0);
    drain();
    check("fc_short_frame", 32'(frame_count), 32'(exp_fc));
    check("pulses_short_frame", 32'(err_pulses - pulses_snap), 32'd1);
    send_frame(144, 143, 2'd1, 8'h00, -1, -1, 30'($urandom), 1'b0, '0);
    drain(); exp_fc++;
    check("fc_after_short", 32'(frame_count), 32'(exp_fc));

    pulses_snap = err_pulses;
    send_frame(144, -1, 2'd0, 8'h00, -1, 143, 30'($urandom), 1'b0, '0);
    send_frame(144, 143, 2'd2, 8'h00, -1, -1, 30'($urandom), 1'b0, '0);
    drain(); exp_fc++;
    check("fc_missing_eop", 32'(frame_count), 32'(exp_fc));
    check("pulses_missing_eop", 32'(err_pulses - pulses_snap), 32'd1);

    send_frame(70, -1, 2'd1, 8'h00, -1, -1, 30'($urandom), 1'b0, '0);
    reset = 1'b0;
    #1;
    check("midrst_src_valid", 32'(src_valid), 32'd0);
    check("midrst_sink_ready", 32'(sink_ready), 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    reset = 1'b1;
    lat_arm_req = 1'b1;
    exp_fc = 0;
    pulses_snap = err_pulses;
    send_frame(144, 143, 2'd0, 8'h00, -1, -1, 30'($urandom), 1'b0, '0);
    drain(); exp_fc++;
    check("fc_after_reset", 32'(frame_count), 32'(exp_fc));
    check("pulses_after_reset", 32'(err_pulses - pulses_snap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
